// File: rtl/i2c_write_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_write_sequencer
//
// Drives the EFB primary I2C controller through the 8-bit WISHBONE transaction
// handler to perform single-register I2C writes:
//   START + device address (write), register address, data byte, STOP.
//
// After reset the block enables the controller and loads the bit-rate
// prescaler. It then waits for host requests. Each request becomes a fixed
// chain of register accesses. Polls of the status register between bytes
// detect a slave NACK or a stuck controller.
//
// Parameters
//   EFB_BASE    WISHBONE base address of the I2C primary block
//   PRESCALE    10-bit I2C clock prescaler written to BR1:BR0
//   POLL_LIMIT  maximum status reads per poll step before giving up
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_start          request pulse, honoured only while o_busy is low
//   i_devAddr        7-bit I2C slave address
//   i_regAddr        slave register address
//   i_data           data byte to write
//   o_busy           high during init and during a transaction
//   o_done           one-cycle pulse at the end of each transaction
//   o_error          NACK or timeout on the last transaction (valid with o_done)
//   o_wbBegin        one-cycle pulse that starts one WISHBONE access
//   o_wbWriteEnable  1 = write, 0 = read
//   o_wbAddress      WISHBONE register address
//   o_wbWriteData    WISHBONE write data
//   i_wbDone         access complete; i_wbReadData valid in the same cycle
//   i_wbReadData     WISHBONE read data
// -----------------------------------------------------------------------------
module i2c_write_sequencer #(
    parameter logic [7:0] EFB_BASE   = 8'h40,
    parameter logic [9:0] PRESCALE   = 10'd100,
    parameter logic [7:0] POLL_LIMIT = 8'd255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [6:0] i_devAddr,
    input  logic [7:0] i_regAddr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_wbBegin,
    output logic       o_wbWriteEnable,
    output logic [7:0] o_wbAddress,
    output logic [7:0] o_wbWriteData,
    input  logic       i_wbDone,
    input  logic [7:0] i_wbReadData
);

    // Top-level FSM encoding
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_EVAL  = 3'd4;

    // Register offsets inside the I2C primary block
    localparam logic [7:0] OFF_CR   = 8'd0;
    localparam logic [7:0] OFF_CMDR = 8'd1;
    localparam logic [7:0] OFF_BR0  = 8'd2;
    localparam logic [7:0] OFF_BR1  = 8'd3;
    localparam logic [7:0] OFF_TXDR = 8'd4;
    localparam logic [7:0] OFF_SR   = 8'd5;

    // Controller command bytes
    localparam logic [7:0] CR_ENABLE    = 8'h80;  // I2CEN
    localparam logic [7:0] CMD_STA_WR   = 8'h94;  // STA | WR | CKSDIS
    localparam logic [7:0] CMD_WR       = 8'h14;  // WR | CKSDIS
    localparam logic [7:0] CMD_STO      = 8'h44;  // STO | CKSDIS

    // Step indices with special handling
    localparam logic [3:0] STEP_LAST_INIT = 4'd2;
    localparam logic [3:0] STEP_FIRST_TX  = 4'd3;
    localparam logic [3:0] STEP_STOP      = 4'd12;
    localparam logic [3:0] STEP_BUSY_POLL = 4'd13;

    logic [2:0] state;
    logic [3:0] step;
    logic [7:0] poll_cnt;

    // Request fields, captured once when a start is accepted
    logic [6:0] dev_addr_q;
    logic [7:0] reg_addr_q;
    logic [7:0] data_q;

    // Status bits captured from the most recent completed access
    logic sr_trrdy_q;
    logic sr_rarc_q;
    logic sr_busy_q;

    // Status bits that the sequencer never inspects
    logic rd_unused;
    assign rd_unused = ^{i_wbReadData[7], i_wbReadData[4:3], i_wbReadData[1:0]};

    logic start_accept;
    logic wb_capture;
    logic poll_expired;

    assign start_accept = (state == S_IDLE) && i_start;
    assign wb_capture   = (state == S_WAIT) && i_wbDone;
    // poll_cnt counts failed reads already seen. The read under evaluation is
    // the last one allowed when POLL_LIMIT-1 reads have failed before it.
    assign poll_expired = (poll_cnt == (POLL_LIMIT - 8'd1));

    // Access decode for the current step
    logic       step_we;
    logic [7:0] step_addr;
    logic [7:0] step_wdata;

    always_comb begin
        step_we    = 1'b1;
        step_addr  = EFB_BASE + OFF_SR;
        step_wdata = 8'h00;
        case (step)
            4'd0: begin
                step_addr  = EFB_BASE + OFF_CR;
                step_wdata = CR_ENABLE;
            end
            4'd1: begin
                step_addr  = EFB_BASE + OFF_BR0;
                step_wdata = PRESCALE[7:0];
            end
            4'd2: begin
                step_addr  = EFB_BASE + OFF_BR1;
                step_wdata = {6'b000000, PRESCALE[9:8]};
            end
            4'd3: begin
                step_addr  = EFB_BASE + OFF_TXDR;
                step_wdata = {dev_addr_q, 1'b0};
            end
            4'd4: begin
                step_addr  = EFB_BASE + OFF_CMDR;
                step_wdata = CMD_STA_WR;
            end
            4'd6: begin
                step_addr  = EFB_BASE + OFF_TXDR;
                step_wdata = reg_addr_q;
            end
            4'd7: begin
                step_addr  = EFB_BASE + OFF_CMDR;
                step_wdata = CMD_WR;
            end
            4'd9: begin
                step_addr  = EFB_BASE + OFF_TXDR;
                step_wdata = data_q;
            end
            4'd10: begin
                step_addr  = EFB_BASE + OFF_CMDR;
                step_wdata = CMD_WR;
            end
            4'd12: begin
                step_addr  = EFB_BASE + OFF_CMDR;
                step_wdata = CMD_STO;
            end
            default: begin
                // Steps 5, 8, 11 and 13 are status reads; 14/15 are
                // unreachable and decode as a harmless status read.
                step_we    = 1'b0;
                step_addr  = EFB_BASE + OFF_SR;
                step_wdata = 8'h00;
            end
        endcase
    end

    // Datapath captures: no reset needed, only read after being written
    always_ff @(posedge i_clk) begin
        if (start_accept) begin
            dev_addr_q <= i_devAddr;
            reg_addr_q <= i_regAddr;
            data_q     <= i_data;
        end
        if (wb_capture) begin
            sr_trrdy_q <= i_wbReadData[2];
            sr_rarc_q  <= i_wbReadData[5];
            sr_busy_q  <= i_wbReadData[6];
        end
    end

    // Control FSM and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= S_INIT;
            step            <= 4'd0;
            poll_cnt        <= 8'd0;
            o_busy          <= 1'b1;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
            o_wbBegin       <= 1'b0;
            o_wbWriteEnable <= 1'b0;
            o_wbAddress     <= 8'h00;
            o_wbWriteData   <= 8'h00;
        end else begin
            o_wbBegin <= 1'b0;
            o_done    <= 1'b0;
            case (state)
                S_INIT: begin
                    step     <= 4'd0;
                    poll_cnt <= 8'd0;
                    state    <= S_ISSUE;
                end

                S_IDLE: begin
                    if (i_start) begin
                        o_busy   <= 1'b1;
                        o_error  <= 1'b0;
                        step     <= STEP_FIRST_TX;
                        poll_cnt <= 8'd0;
                        state    <= S_ISSUE;
                    end
                end

                // Address/data stay registered until the next issue, so they
                // remain stable for the whole access.
                S_ISSUE: begin
                    o_wbWriteEnable <= step_we;
                    o_wbAddress     <= step_addr;
                    o_wbWriteData   <= step_wdata;
                    o_wbBegin       <= 1'b1;
                    state           <= S_WAIT;
                end

                S_WAIT: begin
                    if (i_wbDone) begin
                        state <= S_EVAL;
                    end
                end

                S_EVAL: begin
                    state <= S_ISSUE;
                    case (step)
                        STEP_LAST_INIT: begin
                            o_busy <= 1'b0;
                            state  <= S_IDLE;
                        end

                        4'd5, 4'd8, 4'd11: begin
                            if (sr_trrdy_q && sr_rarc_q) begin
                                // Slave NACKed: abandon remaining bytes, send STOP
                                o_error  <= 1'b1;
                                step     <= STEP_STOP;
                                poll_cnt <= 8'd0;
                            end else if (sr_trrdy_q) begin
                                step     <= step + 4'd1;
                                poll_cnt <= 8'd0;
                            end else if (poll_expired) begin
                                o_error  <= 1'b1;
                                step     <= STEP_STOP;
                                poll_cnt <= 8'd0;
                            end else begin
                                poll_cnt <= poll_cnt + 8'd1;
                            end
                        end

                        STEP_BUSY_POLL: begin
                            if (!sr_busy_q) begin
                                o_busy   <= 1'b0;
                                o_done   <= 1'b1;
                                poll_cnt <= 8'd0;
                                state    <= S_IDLE;
                            end else if (poll_expired) begin
                                o_error  <= 1'b1;
                                o_busy   <= 1'b0;
                                o_done   <= 1'b1;
                                poll_cnt <= 8'd0;
                                state    <= S_IDLE;
                            end else begin
                                poll_cnt <= poll_cnt + 8'd1;
                            end
                        end

                        default: begin
                            step     <= step + 4'd1;
                            poll_cnt <= 8'd0;
                        end
                    endcase
                end

                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
module tb_i2c_write_sequencer;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_start;
    logic [6:0] i_devAddr;
    logic [7:0] i_regAddr;
    logic [7:0] i_data;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic       o_wbBegin;
    logic       o_wbWriteEnable;
    logic [7:0] o_wbAddress;
    logic [7:0] o_wbWriteData;
    logic       i_wbDone;
    logic [7:0] i_wbReadData;

    int checks;
    int errors;

    // Handler model state and access log
    int          acc_n;
    logic [16:0] acc_log [256];
    int          acc_gap [256];
    int          sr_mode;
    int          rd_cnt;
    int          done_cnt;

    i2c_write_sequencer #(
        .EFB_BASE   (8'h40),
        .PRESCALE   (10'd100),
        .POLL_LIMIT (8'd4)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_start         (i_start),
        .i_devAddr       (i_devAddr),
        .i_regAddr       (i_regAddr),
        .i_data          (i_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error),
        .o_wbBegin       (o_wbBegin),
        .o_wbWriteEnable (o_wbWriteEnable),
        .o_wbAddress     (o_wbAddress),
        .o_wbWriteData   (o_wbWriteData),
        .i_wbDone        (i_wbDone),
        .i_wbReadData    (i_wbReadData)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [16:0] wr(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    localparam logic [16:0] RD = 17'h04500;  // read of SR (0x45)

    function automatic logic [7:0] sr_val(input int mode, input int rc);
        if (mode == 1) return 8'h24;                // TRRDY + RARC
        if (mode == 2) return (rc == 0) ? 8'h04 : 8'h00;
        return 8'h04;                               // TRRDY, not busy
    endfunction

    // WISHBONE handler model: acks two cycles after each o_wbBegin
    initial begin
        int pend;
        logic pend_we;
        int since;
        i_wbDone     = 1'b0;
        i_wbReadData = 8'h00;
        acc_n        = 0;
        rd_cnt       = 0;
        pend         = 0;
        pend_we      = 1'b0;
        since        = 1000;
        forever begin
            @(negedge i_clk);
            i_wbDone = 1'b0;
            if (since < 1000) since++;
            if (!i_rst_n) begin
                pend = 0;
            end else if (pend != 0) begin
                pend--;
                if (pend == 0) begin
                    i_wbDone = 1'b1;
                    if (pend_we) begin
                        i_wbReadData = 8'hFF;
                    end else begin
                        i_wbReadData = sr_val(sr_mode, rd_cnt);
                        rd_cnt++;
                    end
                    since = 0;
                end
            end else if (o_wbBegin) begin
                if (acc_n < 256) begin
                    acc_log[acc_n] = {o_wbWriteEnable, o_wbAddress,
                                      o_wbWriteEnable ? o_wbWriteData : 8'h00};
                    acc_gap[acc_n] = since;
                    acc_n++;
                end
                if (o_wbWriteEnable && o_wbAddress == 8'h41 && o_wbWriteData == 8'h94)
                    rd_cnt = 0;
                pend_we = o_wbWriteEnable;
                pend    = 2;
            end
        end
    end

    // o_done pulse counter
    initial begin
        done_cnt = 0;
        forever begin
            @(negedge i_clk);
            if (o_done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  o_busy, 1);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_err"},   o_error, 0);
        chk({tag, "_begin"}, o_wbBegin, 0);
        chk({tag, "_we"},    o_wbWriteEnable, 0);
        chk({tag, "_addr"},  o_wbAddress, 0);
        chk({tag, "_wdata"}, o_wbWriteData, 0);
    endtask

    task automatic wait_busy_low(input string tag, input logic exp_done, input logic exp_err);
        int n;
        n = 0;
        while (o_busy && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_busy_low"}, o_busy, 0);
        chk({tag, "_done"}, o_done, exp_done);
        chk({tag, "_error"}, o_error, exp_err);
    endtask

    // Release reset, check first-access timing and the init sequence
    task automatic release_init(input string tag);
        int base;
        int dc0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        base = acc_n;
        dc0  = done_cnt;
        @(posedge i_clk); #1;
        chk({tag, "_begin_edge1"}, o_wbBegin, 0);
        @(posedge i_clk); #1;
        chk({tag, "_begin_edge2"}, o_wbBegin, 1);
        chk({tag, "_first_acc"}, {o_wbWriteEnable, o_wbAddress, o_wbWriteData}, wr(8'h40, 8'h80));
        // start pulse during init must be ignored
        @(negedge i_clk);
        i_devAddr = 7'h11; i_regAddr = 8'h22; i_data = 8'h33;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_busy_low({tag, "_init"}, 1'b0, 1'b0);
        repeat (6) @(negedge i_clk);
        chk({tag, "_idle_busy"}, o_busy, 0);
        chk({tag, "_init_count"}, acc_n - base, 3);
        chk({tag, "_init0"}, acc_log[base],     wr(8'h40, 8'h80));
        chk({tag, "_init1"}, acc_log[base + 1], wr(8'h42, 8'h64));
        chk({tag, "_init2"}, acc_log[base + 2], wr(8'h43, 8'h00));
        chk({tag, "_init_gap"}, acc_gap[base + 2], 3);
        chk({tag, "_no_done"}, done_cnt, dc0);
    endtask

    // Accepted start: busy next cycle, step-3 access one cycle after that
    task automatic do_start(input string tag, input logic [6:0] dev,
                            input logic [7:0] ra, input logic [7:0] d);
        @(negedge i_clk);
        i_devAddr = dev; i_regAddr = ra; i_data = d;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        chk({tag, "_busy_rise"}, o_busy, 1);
        chk({tag, "_err_clr"}, o_error, 0);
        chk({tag, "_begin_early"}, o_wbBegin, 0);
        @(posedge i_clk); #1;
        chk({tag, "_begin_step3"}, o_wbBegin, 1);
        chk({tag, "_step3_acc"}, {o_wbWriteEnable, o_wbAddress, o_wbWriteData},
            wr(8'h44, {dev, 1'b0}));
    endtask

    initial begin
        int base;
        int dc0;
        bit found;
        logic [16:0] ea [11];
        logic [16:0] eb [5];
        logic [16:0] ec [11];

        checks    = 0;
        errors    = 0;
        sr_mode   = 0;
        i_start   = 1'b0;
        i_devAddr = 7'h00;
        i_regAddr = 8'h00;
        i_data    = 8'h00;
        i_rst_n   = 1'b1;
        #2 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_reset_outputs("rst0");

        release_init("init0");

        // Normal transaction, every poll satisfied immediately
        sr_mode = 0;
        base = acc_n; dc0 = done_cnt;
        do_start("txA", 7'h48, 8'h05, 8'hA5);
        wait_busy_low("txA", 1'b1, 1'b0);
        @(negedge i_clk);
        chk("txA_done_pulse", o_done, 0);
        chk("txA_done_cnt", done_cnt, dc0 + 1);
        chk("txA_count", acc_n - base, 11);
        ea = '{wr(8'h44, 8'h90), wr(8'h41, 8'h94), RD, wr(8'h44, 8'h05), wr(8'h41, 8'h14), RD,
               wr(8'h44, 8'hA5), wr(8'h41, 8'h14), RD, wr(8'h41, 8'h44), RD};
        for (int i = 0; i < 11; i++) chk($sformatf("txA_acc%0d", i), acc_log[base + i], ea[i]);
        for (int i = 1; i < 11; i++) chk($sformatf("txA_gap%0d", i), acc_gap[base + i], 3);

        // NACK on the address byte
        sr_mode = 1;
        base = acc_n; dc0 = done_cnt;
        do_start("txB", 7'h3C, 8'h22, 8'h99);
        wait_busy_low("txB", 1'b1, 1'b1);
        repeat (3) @(negedge i_clk);
        chk("txB_err_held", o_error, 1);
        chk("txB_done_low", o_done, 0);
        chk("txB_done_cnt", done_cnt, dc0 + 1);
        chk("txB_count", acc_n - base, 5);
        eb = '{wr(8'h44, 8'h78), wr(8'h41, 8'h94), RD, wr(8'h41, 8'h44), RD};
        for (int i = 0; i < 5; i++) chk($sformatf("txB_acc%0d", i), acc_log[base + i], eb[i]);

        // TRRDY never returns after the register byte: 4 reads then STOP
        sr_mode = 2;
        base = acc_n; dc0 = done_cnt;
        do_start("txC", 7'h50, 8'h10, 8'h33);
        wait_busy_low("txC", 1'b1, 1'b1);
        @(negedge i_clk);
        chk("txC_done_cnt", done_cnt, dc0 + 1);
        chk("txC_count", acc_n - base, 11);
        ec = '{wr(8'h44, 8'hA0), wr(8'h41, 8'h94), RD, wr(8'h44, 8'h10), wr(8'h41, 8'h14),
               RD, RD, RD, RD, wr(8'h41, 8'h44), RD};
        for (int i = 0; i < 11; i++) chk($sformatf("txC_acc%0d", i), acc_log[base + i], ec[i]);

        // Start pulse and input changes mid-transaction are ignored
        sr_mode = 0;
        base = acc_n; dc0 = done_cnt;
        do_start("txD", 7'h21, 8'h7E, 8'h01);
        repeat (10) @(negedge i_clk);
        i_devAddr = 7'h7F; i_regAddr = 8'hEE; i_data = 8'hDD;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_busy_low("txD", 1'b1, 1'b0);
        repeat (20) @(negedge i_clk);
        chk("txD_stays_idle", o_busy, 0);
        chk("txD_done_cnt", done_cnt, dc0 + 1);
        chk("txD_count", acc_n - base, 11);
        ea = '{wr(8'h44, 8'h42), wr(8'h41, 8'h94), RD, wr(8'h44, 8'h7E), wr(8'h41, 8'h14), RD,
               wr(8'h44, 8'h01), wr(8'h41, 8'h14), RD, wr(8'h41, 8'h44), RD};
        for (int i = 0; i < 11; i++) chk($sformatf("txD_acc%0d", i), acc_log[base + i], ea[i]);

        // Reset while the data-byte write is outstanding
        sr_mode = 0;
        dc0 = done_cnt;
        do_start("txE", 7'h48, 8'h05, 8'hA5);
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge i_clk);
            if (o_wbBegin && o_wbWriteEnable && o_wbAddress == 8'h44 && o_wbWriteData == 8'hA5)
                found = 1'b1;
        end
        chk("txE_step9_seen", found, 1);
        #2;
        chk("txE_begin_before_rst", o_wbBegin, 1);
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("rstE");
        repeat (4) @(negedge i_clk);
        chk_reset_outputs("rstE_hold");
        release_init("init1");
        chk("txE_no_done", done_cnt, dc0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
